// File: rtl/hazard_seq_unit_if.sv
// Hazard sequencer bus: pipeline event inputs in, per-boundary stall/flush
// vectors and sequence status out. The pipeline side drives the master end.
interface hazard_seq_unit_if #(
   parameter int STAGES = 2
);
   logic              i_branch_taken;
   logic              i_push_pc;
   logic              i_pop_pc;
   logic              i_interrupt_req;
   logic              i_decode_imm;
   logic              i_exm_imm;
   logic [STAGES-1:0] o_flush;
   logic [STAGES-1:0] o_stall;
   logic              o_pc_redirect;
   logic              o_insert_nop;
   logic              o_int_ack;
   logic              o_busy;
   logic [1:0]        o_state;
   logic              o_protocol_err;

   modport master (
      output i_branch_taken, i_push_pc, i_pop_pc, i_interrupt_req,
             i_decode_imm, i_exm_imm,
      input  o_flush, o_stall, o_pc_redirect, o_insert_nop, o_int_ack,
             o_busy, o_state, o_protocol_err
   );

   modport slave (
      input  i_branch_taken, i_push_pc, i_pop_pc, i_interrupt_req,
             i_decode_imm, i_exm_imm,
      output o_flush, o_stall, o_pc_redirect, o_insert_nop, o_int_ack,
             o_busy, o_state, o_protocol_err
   );
endinterface

// File: rtl/hazard_seq_unit.sv
// Hazard sequencer: runs multi-cycle CALL / RET / INTERRUPT sequences and
// produces per-boundary stall/flush vectors. Bit 0 is the fetch/decode
// boundary, bit STAGES-1 the oldest (decode/exm). Interrupts are latched and
// held off while decode holds the first word of a two-word instruction.
module hazard_seq_unit #(
   parameter int STAGES      = 2,
   parameter int CALL_CYCLES = 2,
   parameter int RET_CYCLES  = 2,
   parameter int INT_CYCLES  = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   hazard_seq_unit_if.slave bus
);

   localparam int MAX_A = (CALL_CYCLES > RET_CYCLES) ? CALL_CYCLES : RET_CYCLES;
   localparam int MAX_C = (MAX_A > INT_CYCLES) ? MAX_A : INT_CYCLES;
   localparam int CW    = $clog2(MAX_C) + 1;
   localparam int TOP   = STAGES - 1;

   localparam logic [CW-1:0] CALL_LAST = CW'(CALL_CYCLES - 1);
   localparam logic [CW-1:0] RET_LAST  = CW'(RET_CYCLES - 1);
   localparam logic [CW-1:0] INT_LAST  = CW'(INT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   // Hold every boundary except the oldest, which drains as a bubble.
   localparam logic [STAGES-1:0] SEQ_STALL = {1'b0, {(STAGES-1){1'b1}}};
   localparam logic [STAGES-1:0] SEQ_FLUSH = {1'b1, {(STAGES-1){1'b0}}};
   localparam logic [STAGES-1:0] ALL_ONES  = {STAGES{1'b1}};
   localparam logic [STAGES-1:0] FLUSH_F   = {{(STAGES-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALL = 2'd1,
      S_RET  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              pend_q;
   logic              err_q;

   logic [STAGES-1:0] flush_c, stall_c;
   logic              redirect_c, nop_c, ack_c, err_set;
   logic              int_want;

   assign int_want = (pend_q | bus.i_interrupt_req) & ~bus.i_decode_imm;

   // Sequence registers; reset aborts any sequence and drops a pending interrupt.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         // A new request in the ack cycle stays latched.
         pend_q  <= bus.i_interrupt_req | (pend_q & ~ack_c);
         err_q   <= err_q | err_set;
      end
   end

   // Next-state decode and per-cycle stall/flush/redirect generation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      flush_c    = '0;
      stall_c    = '0;
      redirect_c = 1'b0;
      nop_c      = 1'b0;
      ack_c      = 1'b0;
      err_set    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.i_branch_taken) begin
               flush_c    = ALL_ONES;
               redirect_c = 1'b1;
            end else if (bus.i_pop_pc) begin
               if (RET_CYCLES == 1) begin
                  redirect_c = 1'b1;
                  flush_c    = ALL_ONES;
               end else begin
                  stall_c = SEQ_STALL;
                  flush_c = SEQ_FLUSH;
                  state_d = S_RET;
                  cnt_d   = CNT_ONE;
               end
            end else if (bus.i_push_pc) begin
               if (CALL_CYCLES == 1) begin
                  redirect_c = 1'b1;
                  flush_c    = FLUSH_F;
               end else begin
                  stall_c = SEQ_STALL;
                  flush_c = SEQ_FLUSH;
                  state_d = S_CALL;
                  cnt_d   = CNT_ONE;
               end
            end else if (int_want) begin
               // Interrupt entry: freeze fetch and feed decode a NOP.
               nop_c      = 1'b1;
               stall_c[0] = 1'b1;
               state_d    = S_INT;
               cnt_d      = CNT_ONE;
            end
         end

         S_CALL: begin
            if (cnt_q == CALL_LAST) begin
               redirect_c = 1'b1;
               flush_c    = FLUSH_F;
               state_d    = S_IDLE;
               cnt_d      = '0;
            end else begin
               stall_c = SEQ_STALL;
               flush_c = SEQ_FLUSH;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         S_RET: begin
            if (cnt_q == RET_LAST) begin
               redirect_c = 1'b1;
               flush_c    = ALL_ONES;
               state_d    = S_IDLE;
               cnt_d      = '0;
            end else begin
               stall_c = SEQ_STALL;
               flush_c = SEQ_FLUSH;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         S_INT: begin
            if (cnt_q == INT_LAST) begin
               redirect_c = 1'b1;
               flush_c    = ALL_ONES;
               ack_c      = 1'b1;
               state_d    = S_IDLE;
               cnt_d      = '0;
            end else begin
               stall_c = SEQ_STALL;
               flush_c = SEQ_FLUSH;
               cnt_d   = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // An immediate word in exm is never executed as an instruction.
      if (bus.i_exm_imm) flush_c[TOP] = 1'b1;

      // A branch resolving mid-sequence is a protocol violation; still
      // squash everything, but let the sequence run to completion.
      if (state_q != S_IDLE && bus.i_branch_taken) begin
         flush_c = ALL_ONES;
         err_set = 1'b1;
      end
   end

   // Outputs are forced quiet while reset is held.
   always_comb begin
      bus.o_flush        = i_rst ? '0 : flush_c;
      bus.o_stall        = i_rst ? '0 : stall_c;
      bus.o_pc_redirect  = ~i_rst & redirect_c;
      bus.o_insert_nop   = ~i_rst & nop_c;
      bus.o_int_ack      = ~i_rst & ack_c;
      bus.o_busy         = ~i_rst & (state_q != S_IDLE);
      bus.o_state        = i_rst ? 2'b00 : state_q;
      bus.o_protocol_err = ~i_rst & (err_q | err_set);
   end

endmodule

// File: doc/hazard_seq_unit.md
Name: hazard_seq_unit

Overview:
Parametrised successor to the two-stage call/ret hazard controller. Generates per-boundary stall and flush vectors for an arbitrary number of pipeline boundaries. Runs multi-cycle CALL / RET / INTERRUPT sequences whose lengths are parameters, and latches interrupt requests until they can be serviced without splitting a two-word instruction. Sits beside the pipeline registers; fetch/decode/exm consume its vectors directly.

Parameters:
STAGES, 2, number of pipeline boundaries; bit 0 = fetch/decode, bit STAGES-1 = oldest (decode/exm); legal >=2
CALL_CYCLES, 2, length of CALL sequence in cycles; legal >=1
RET_CYCLES, 2, length of RET sequence in cycles; legal >=1
INT_CYCLES, 3, length of INTERRUPT sequence in cycles; legal >=2

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  synchronous active-high reset
i_branch_taken  input  1  branch resolved taken this cycle
i_push_pc  input  1  call/push-PC instruction in exm
i_pop_pc  input  1  ret/pop-PC instruction in exm
i_interrupt_req  input  1  interrupt request (pulse or level)
i_decode_imm  input  1  decode holds first word of a two-word instruction
i_exm_imm  input  1  exm holds an immediate word (not an instruction)
o_flush  output  STAGES  per-boundary flush
o_stall  output  STAGES  per-boundary stall
o_pc_redirect  output  1  take redirected PC this cycle
o_insert_nop  output  1  inject NOP into decode
o_int_ack  output  1  interrupt accepted (one cycle)
o_busy  output  1  sequence in progress (state != IDLE)
o_state  output  2  IDLE=0, CALL=1, RET=2, INT=3
o_protocol_err  output  1  sticky error flag

Behaviour:
- Registered state: FSM state, cycle counter cnt (width clog2(max cycles)+1), int_pending, err flag. All other outputs combinational.
- Reset: state=IDLE, cnt=0, int_pending=0, err=0. While i_rst=1 all outputs forced 0. Reset mid-sequence aborts to IDLE next cycle; pending interrupt discarded.
- int_pending: set on i_interrupt_req, cleared on o_int_ack. Set wins when both occur in the same cycle.
- IDLE priority, highest first:
  1. i_branch_taken: o_flush=all ones, o_pc_redirect=1; push/pop/interrupt ignored this cycle.
  2. i_pop_pc: start RET; pop wins over a simultaneous push.
  3. i_push_pc: start CALL.
  4. (int_pending | i_interrupt_req) & ~i_decode_imm: start INT.
- Sequence cycle k=0 is the IDLE cycle in which the start is decoded. If length>1, FSM enters the sequence state with cnt=1. Final cycle is k=length-1; FSM returns to IDLE after it. A length-1 sequence completes in the IDLE cycle and the FSM stays in IDLE.
- Non-final CALL/RET cycles, and INT cycles 1..INT_CYCLES-2: o_stall = all ones except bit STAGES-1 = 0; o_flush[STAGES-1]=1 (bubble); o_busy=1 when not IDLE.
- INT cycle 0: o_insert_nop=1, o_stall[0]=1, all else 0.
- Final CALL: o_pc_redirect=1, o_flush[0]=1.
- Final RET: o_pc_redirect=1, o_flush=all ones.
- Final INT: o_pc_redirect=1, o_flush=all ones, o_int_ack=1.
- i_exm_imm: ORs 1 into o_flush[STAGES-1] in every state.
- In non-IDLE states, i_push_pc, i_pop_pc and i_interrupt_req do not start a new sequence (an interrupt request is only latched).
- i_branch_taken while busy: still ORs all ones into o_flush; sets o_protocol_err (sticky until reset); sequence continues.
- An interrupt blocked by i_decode_imm stays pending; it starts on the first IDLE cycle with i_decode_imm=0 and no branch/push/pop.

Test Plan:
- Defaults; reset held 2 cycles, then push_pc pulse 1 cycle -> k0: o_stall=01, o_flush=10; k1: o_state=1, o_pc_redirect=1, o_flush=01; k2: o_state=0, all outputs 0.
- push_pc=pop_pc=1 in IDLE -> RET chosen; k1: o_flush=11, o_pc_redirect=1, o_state=2.
- Interrupt pulse while i_decode_imm=1 for 3 cycles -> no start. Next cycle: o_insert_nop=1, o_stall=01. Then o_flush=10 for 1 cycle, then o_int_ack=1 with o_flush=11. Pending cleared afterwards.
- Branch_taken with push_pc and interrupt_req in IDLE -> o_flush=11, o_pc_redirect=1, state stays 0. Interrupt serviced next cycle.
- i_rst asserted during RET k1 -> outputs 0 that cycle; state=0 next cycle; earlier pending interrupt not serviced.
- STAGES=4, RET_CYCLES=3, branch_taken at RET k1 -> o_flush=1111 that cycle, o_protocol_err=1 and remains 1; RET completes at k2 with o_flush=1111.
